fp_mul_post: RTL and testbench
==============================

# fp_mul_post

Post-processing stage placed directly downstream of the combinational double-precision multiplier `fp_multiplier`. It receives the multiplier's raw packed product together with the original operands. It then:
- detects IEEE-754 special cases,
- resolves exponent overflow and underflow, which the multiplier's 11-bit exponent arithmetic cannot represent,
- registers the corrected result behind a valid/ready handshake,
- accumulates sticky exception flags for the FPU status register.

## Interface
Parameters:
- `CANON_NAN`, default 64'h7FF8_0000_0000_0000. Value emitted for every invalid operation.

Ports:
- `clk` in 1: single clock. All state changes on the rising edge.
- `rst_n` in 1: synchronous, active-low reset. Sampled on the rising edge of `clk`.
- `in_valid` in 1: operands and raw product are valid this cycle.
- `in_ready` out 1: stage can accept an input this cycle.
- `op_a`, `op_b` in 64 each: the operands presented to `fp_multiplier`.
- `raw_result` in 64: `fp_multiplier.result` for `op_a`/`op_b`.
- `out_valid` out 1: `out_result` and `out_flags` are valid.
- `out_ready` in 1: consumer accepts the output this cycle.
- `out_result` out 64: corrected product.
- `out_flags` out 3: per-result flags {invalid, overflow, underflow}.
- `sticky_flags` out 3: OR-accumulation of every accepted result's flags.
- `flags_clr` in 1: single-cycle pulse that clears `sticky_flags`.

## Operation
- **Accept:** an input is accepted when `in_valid && in_ready`.
  - `in_ready = !out_valid || out_ready`. This gives a single output register with pass-through ready.
- **Operand classification** (per operand, from exponent field `e` and mantissa `m`):
  - NaN: `e == 2047 && m != 0`.
  - Inf: `e == 2047 && m == 0`.
  - Zero: `e == 0`. Subnormals are flushed to zero and raise no flag.
  - Normal: all other encodings.
- **Sign:** `s = op_a[63] ^ op_b[63]`.
- **Carry recovery:** compute `base = ({2'b0, eA} + {2'b0, eB}) - 1023` as a 13-bit signed value.
  - `carry = (raw_result[62:52] != base[10:0])`.
  - True exponent: `E = base + carry`, 13-bit signed.
- **Result selection** (first matching rule wins):
  1. Either operand NaN, or Inf×Zero in either order: `CANON_NAN`, invalid = 1.
  2. Either operand Inf: `{s, 11'h7FF, 52'h0}`.
  3. Either operand Zero: `{s, 63'h0}`.
  4. `E >= 2047`: `{s, 11'h7FF, 52'h0}`, overflow = 1.
  5. `E <= 0`: `{s, 63'h0}`, underflow = 1.
  6. Otherwise: `raw_result` unchanged.
- **Output register:**
  - On accept, load `out_result`/`out_flags` and set `out_valid`.
  - If `out_valid && out_ready` and there is no accept in the same cycle, clear `out_valid`.
  - While `out_valid && !out_ready`, `out_result` and `out_flags` hold stable.
- **Sticky flags:**
  - `sticky_next = (flags_clr ? 0 : sticky) | (accept ? new_flags : 0)`.
  - When a clear and a set coincide, the set wins.

## Timing
- Latency is 1 cycle: an input accepted at edge N appears with `out_valid` = 1 after edge N.
- Throughput is 1 result per cycle while `out_ready` = 1.
- Simultaneous output drain and new accept: the register reloads and `out_valid` stays 1, with no bubble.
- Reset values: `out_valid` 0, `out_result` 0, `out_flags` 0, `sticky_flags` 0.
  - `in_ready` is 1 in the first cycle after reset.
- Reset asserted mid-transfer: a pending output is discarded and the sticky flags clear.
  - Inputs presented in a cycle where `rst_n` = 0 are not accepted.
- `flags_clr` is ignored while `rst_n` = 0, since reset already clears.
- No combinational path from `in_valid` to `in_ready`.
- Combinational path from `out_ready` to `in_ready` is permitted.

## Structure
- Shared package `fp_pkg` holds:
  - `FP_EXP_BIAS` = 1023 and `FP_EXP_MAX` = 2047.
  - Default `FP_CANON_NAN`.
  - Flag bit indices `FLG_INV` = 2, `FLG_OVF` = 1, `FLG_UNF` = 0.
  - A packed struct for {sign, exp[10:0], mant[51:0]}.
- Sub-module `fp_classify`: combinational, 64-bit in, outputs `is_nan`, `is_inf`, `is_zero`. Instantiated once per operand.
- Everything else (carry recovery, select, register, sticky logic) lives in `fp_mul_post`.

## Test plan
- **Normal product:** `op_a` = 0x4000000000000000, `op_b` = 0x4008000000000000, `raw_result` = 0x4018000000000000, `out_ready` = 1.
  - Required: 1 cycle later `out_result` = 0x4018000000000000 (2.0×3.0 = 6.0), `out_flags` = 0.
- **Invalid:** `op_a` = 0x7FF0000000000000, `op_b` = 0x0000000000000000.
  - Required: `out_result` = 0x7FF8000000000000, `out_flags` = 3'b100, `sticky_flags` = 3'b100.
- **Overflow:** `op_a` = 0x7FE0000000000000, `op_b` = 0xC000000000000000, with `raw_result` from the multiplier.
  - Required: `out_result` = 0xFFF0000000000000, `out_flags` = 3'b010.
- **Underflow:** `op_a` = `op_b` = 0x0010000000000000.
  - Required: `out_result` = 0x0000000000000000, `out_flags` = 3'b001.
  - Then pulse `flags_clr` in the same cycle as an accepted overflow input. Required: `sticky_flags` = 3'b010.
- **Backpressure:** stream 4 back-to-back inputs with `out_ready` low for 3 cycles.
  - Required: `in_ready` = 0 while the output is held, `out_result` stable, no input lost or duplicated, results delivered in order.
- **Reset mid-operation:** drive `rst_n` = 0 for 1 cycle while `out_valid` = 1.
  - Required: next cycle `out_valid` = 0, `sticky_flags` = 0, `in_ready` = 1.

Source files
------------

// File: rtl/fp_pkg.sv
// Shared double-precision constants, flag indices and field layout
// for the multiplier post-processing stage.
package fp_pkg;

   localparam int FP_EXP_BIAS = 1023;
   localparam int FP_EXP_MAX  = 2047;

   localparam logic [63:0] FP_CANON_NAN = 64'h7FF8_0000_0000_0000;

   localparam int FLG_INV = 2;
   localparam int FLG_OVF = 1;
   localparam int FLG_UNF = 0;

   typedef struct packed {
      logic        sign;
      logic [10:0] exp;
      logic [51:0] mant;
   } fp64_t;

endpackage

// File: rtl/fp_classify.sv
// Classifies one binary64 operand; subnormals count as zero.
module fp_classify
   import fp_pkg::*;
(
   input  logic [63:0] op,
   output logic        is_nan,
   output logic        is_inf,
   output logic        is_zero
);

   fp64_t f;
   logic  exp_max;
   logic  mant_nz;

   assign f       = op;
   assign exp_max = (f.exp == 11'(FP_EXP_MAX));
   assign mant_nz = |f.mant;

   assign is_nan  = exp_max && mant_nz;
   assign is_inf  = exp_max && !mant_nz;
   assign is_zero = (f.exp == 11'd0);

endmodule

// File: rtl/fp_mul_post.sv
// Special-case, overflow and underflow fix-up behind a one-entry
// output register, with sticky exception flags.
module fp_mul_post
   import fp_pkg::*;
#(
   parameter logic [63:0] CANON_NAN = FP_CANON_NAN
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [63:0] op_a,
   input  logic [63:0] op_b,
   input  logic [63:0] raw_result,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [63:0] out_result,
   output logic [2:0]  out_flags,
   output logic [2:0]  sticky_flags,
   input  logic        flags_clr
);

   fp64_t fa;
   fp64_t fb;
   fp64_t fr;

   logic a_nan, a_inf, a_zero;
   logic b_nan, b_inf, b_zero;

   logic               sgn;
   logic [12:0]        exp_sum;
   logic signed [12:0] base;
   logic signed [12:0] e_true;
   logic               carry;

   logic [63:0] new_result;
   logic [2:0]  new_flags;
   logic        accept;

   assign fa = op_a;
   assign fb = op_b;
   assign fr = raw_result;

   fp_classify u_cls_a (
      .op      (op_a),
      .is_nan  (a_nan),
      .is_inf  (a_inf),
      .is_zero (a_zero)
   );

   fp_classify u_cls_b (
      .op      (op_b),
      .is_nan  (b_nan),
      .is_inf  (b_inf),
      .is_zero (b_zero)
   );

   assign sgn = fa.sign ^ fb.sign;

   // The multiplier only reports 11 exponent bits; a mismatch against
   // the unnormalised sum reveals that it renormalised by one.
   assign exp_sum = {2'b0, fa.exp} + {2'b0, fb.exp};
   assign base    = $signed(exp_sum - 13'(FP_EXP_BIAS));
   assign carry   = (fr.exp != base[10:0]);
   assign e_true  = base + $signed({12'b0, carry});

   always_comb begin
      new_result = raw_result;
      new_flags  = 3'b000;
      if (a_nan || b_nan || (a_inf && b_zero) || (a_zero && b_inf)) begin
         new_result         = CANON_NAN;
         new_flags[FLG_INV] = 1'b1;
      end else if (a_inf || b_inf) begin
         new_result = {sgn, 11'h7FF, 52'h0};
      end else if (a_zero || b_zero) begin
         new_result = {sgn, 63'h0};
      end else if (e_true >= $signed(13'(FP_EXP_MAX))) begin
         new_result         = {sgn, 11'h7FF, 52'h0};
         new_flags[FLG_OVF] = 1'b1;
      end else if (e_true <= 13'sd0) begin
         new_result         = {sgn, 63'h0};
         new_flags[FLG_UNF] = 1'b1;
      end
   end

   assign in_ready = !out_valid || out_ready;
   assign accept   = in_valid && in_ready;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_valid    <= 1'b0;
         out_result   <= 64'h0;
         out_flags    <= 3'b000;
         sticky_flags <= 3'b000;
      end else begin
         if (accept) begin
            out_valid  <= 1'b1;
            out_result <= new_result;
            out_flags  <= new_flags;
         end else if (out_ready) begin
            out_valid  <= 1'b0;
         end
         // A set in the same cycle as a clear survives.
         sticky_flags <= (flags_clr ? 3'b000 : sticky_flags)
                       | (accept ? new_flags : 3'b000);
      end
   end

endmodule

// File: tb/tb_fp_mul_post.sv
// Directed and randomized checks of fp_mul_post against a
// behavioural IEEE-754 product fix-up model.
module tb_fp_mul_post;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [63:0] op_a;
   logic [63:0] op_b;
   logic [63:0] raw_result;
   logic        out_valid;
   logic        out_ready;
   logic [63:0] out_result;
   logic [2:0]  out_flags;
   logic [2:0]  sticky_flags;
   logic        flags_clr;

   int n_cmp = 0;
   int n_bad = 0;

   logic [66:0] q[$];
   logic [2:0]  sticky_m = 3'b000;

   always #5 clk = ~clk;

   fp_mul_post dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .op_a         (op_a),
      .op_b         (op_b),
      .raw_result   (raw_result),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_result   (out_result),
      .out_flags    (out_flags),
      .sticky_flags (sticky_flags),
      .flags_clr    (flags_clr)
   );

   // Truncating binary64 multiply, standing in for fp_multiplier.
   function automatic logic [63:0] gen_raw(logic [63:0] a, logic [63:0] b);
      logic [105:0] p;
      logic [51:0]  m;
      int           c;
      int           e;
      p = 106'({1'b1, a[51:0]}) * 106'({1'b1, b[51:0]});
      c = p[105] ? 1 : 0;
      m = p[105] ? p[104:53] : p[103:52];
      e = int'(a[62:52]) + int'(b[62:52]) - 1023 + c;
      return {a[63] ^ b[63], 11'(e), m};
   endfunction

   // Returns {result, flags} from the product rules in plain integers.
   function automatic logic [66:0] ref_model(logic [63:0] a, logic [63:0] b,
                                             logic [63:0] raw);
      int ea;
      int eb;
      int base;
      int e;
      bit na, nb, ia, ib, za, zb, s;
      ea   = int'(a[62:52]);
      eb   = int'(b[62:52]);
      na   = (ea == 2047) && (a[51:0] != 0);
      nb   = (eb == 2047) && (b[51:0] != 0);
      ia   = (ea == 2047) && (a[51:0] == 0);
      ib   = (eb == 2047) && (b[51:0] == 0);
      za   = (ea == 0);
      zb   = (eb == 0);
      s    = a[63] ^ b[63];
      base = ea + eb - 1023;
      e    = base + ((int'(raw[62:52]) != (base & 2047)) ? 1 : 0);
      if (na || nb || (ia && zb) || (za && ib))
         return {64'h7FF8_0000_0000_0000, 3'b100};
      if (ia || ib) return {s, 11'h7FF, 52'h0, 3'b000};
      if (za || zb) return {s, 63'h0, 3'b000};
      if (e >= 2047) return {s, 11'h7FF, 52'h0, 3'b010};
      if (e <= 0) return {s, 63'h0, 3'b001};
      return {raw, 3'b000};
   endfunction

   function automatic logic [63:0] rand_op();
      logic [63:0] w;
      int          e;
      w = {$urandom, $urandom};
      case ($urandom_range(0, 5))
         0:       e = 0;
         1:       e = 2047;
         2:       e = $urandom_range(1, 40);
         3:       e = $urandom_range(2000, 2046);
         default: e = $urandom_range(1, 2046);
      endcase
      if (e == 2047 && $urandom_range(0, 1) == 0) w[51:0] = 52'h0;
      return {w[63], 11'(e), w[51:0]};
   endfunction

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      n_cmp++;
      assert (got === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%h expected=%h", tag, got, exp);
      end
   endtask

   // One clock of stimulus; checks outputs against the model queue.
   task automatic cycle(input logic r, input logic v, input logic [63:0] a,
                        input logic [63:0] b, input logic [63:0] raw,
                        input logic ordy, input logic clr, output logic acc);
      logic        exp_rdy;
      logic [66:0] ent;
      logic [2:0]  nf;
      rst_n      = r;
      in_valid   = v;
      op_a       = a;
      op_b       = b;
      raw_result = raw;
      out_ready  = ordy;
      flags_clr  = clr;
      acc        = 1'b0;
      #2;
      if (r) begin
         exp_rdy = (q.size() == 0) || ordy;
         chk("in_ready", 64'(in_ready), 64'(exp_rdy));
         chk("out_valid", 64'(out_valid), 64'(q.size() != 0));
         if (q.size() != 0) begin
            chk("out_result", out_result, q[0][66:3]);
            chk("out_flags", 64'(out_flags), 64'(q[0][2:0]));
            if (ordy) void'(q.pop_front());
         end
         nf  = 3'b000;
         acc = v && exp_rdy;
         if (acc) begin
            ent = ref_model(a, b, raw);
            q.push_back(ent);
            nf = ent[2:0];
         end
         sticky_m = (clr ? 3'b000 : sticky_m) | nf;
      end else begin
         q.delete();
         sticky_m = 3'b000;
      end
      @(posedge clk);
      #1;
      chk("sticky", 64'(sticky_flags), 64'(sticky_m));
   endtask

   initial begin
      logic        acc;
      logic [63:0] a;
      logic [63:0] b;
      int          k;

      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; flags_clr = 1'b0;
      op_a = '0; op_b = '0; raw_result = '0;
      @(posedge clk);
      #1;
      cycle(1'b0, 1'b1, 64'h4000_0000_0000_0000, 64'h4000_0000_0000_0000,
            64'h4010_0000_0000_0000, 1'b1, 1'b1, acc);
      chk("rst_out_valid", 64'(out_valid), 64'h0);
      chk("rst_out_result", out_result, 64'h0);
      chk("rst_out_flags", 64'(out_flags), 64'h0);
      chk("rst_sticky", 64'(sticky_flags), 64'h0);
      rst_n = 1'b1;
      #1;
      chk("rst_in_ready", 64'(in_ready), 64'h1);

      cycle(1'b1, 1'b1, 64'h4000_0000_0000_0000, 64'h4008_0000_0000_0000,
            64'h4018_0000_0000_0000, 1'b1, 1'b0, acc);
      chk("mul_result", out_result, 64'h4018_0000_0000_0000);
      chk("mul_flags", 64'(out_flags), 64'h0);

      cycle(1'b1, 1'b1, 64'h7FF0_0000_0000_0000, 64'h0,
            64'h7FF0_0000_0000_0000, 1'b1, 1'b0, acc);
      chk("inv_result", out_result, 64'h7FF8_0000_0000_0000);
      chk("inv_flags", 64'(out_flags), 64'h4);
      chk("inv_sticky", 64'(sticky_flags), 64'h4);

      cycle(1'b1, 1'b1, 64'h7FE0_0000_0000_0000, 64'hC000_0000_0000_0000,
            64'hFFF0_0000_0000_0000, 1'b1, 1'b0, acc);
      chk("ovf_result", out_result, 64'hFFF0_0000_0000_0000);
      chk("ovf_flags", 64'(out_flags), 64'h2);

      cycle(1'b1, 1'b1, 64'h0010_0000_0000_0000, 64'h0010_0000_0000_0000,
            64'h4030_0000_0000_0000, 1'b1, 1'b0, acc);
      chk("unf_result", out_result, 64'h0);
      chk("unf_flags", 64'(out_flags), 64'h1);
      chk("unf_sticky", 64'(sticky_flags), 64'h7);

      cycle(1'b1, 1'b1, 64'h7FE0_0000_0000_0000, 64'hC000_0000_0000_0000,
            64'hFFF0_0000_0000_0000, 1'b1, 1'b1, acc);
      chk("clr_set_sticky", 64'(sticky_flags), 64'h2);
      cycle(1'b1, 1'b0, '0, '0, '0, 1'b1, 1'b0, acc);

      k = 0;
      for (int i = 0; i < 4; i++) begin
         a   = {2'b00, 10'($urandom_range(900, 1100)), 52'($urandom)};
         b   = {2'b01, 10'($urandom_range(0, 100)), 52'($urandom)};
         acc = 1'b0;
         while (!acc && k < 40) begin
            cycle(1'b1, 1'b1, a, b, gen_raw(a, b),
                  !(k >= 1 && k <= 3), 1'b0, acc);
            k++;
         end
      end
      chk("bp_budget", 64'(k < 40), 64'h1);
      cycle(1'b1, 1'b0, '0, '0, '0, 1'b1, 1'b0, acc);
      chk("bp_drained", 64'(out_valid), 64'h0);

      a = 64'h3FF8_0000_0000_0000;
      cycle(1'b1, 1'b1, a, a, gen_raw(a, a), 1'b0, 1'b0, acc);
      cycle(1'b0, 1'b1, a, a, gen_raw(a, a), 1'b0, 1'b1, acc);
      chk("midrst_out_valid", 64'(out_valid), 64'h0);
      chk("midrst_sticky", 64'(sticky_flags), 64'h0);
      rst_n = 1'b1;
      in_valid = 1'b0;
      #1;
      chk("midrst_in_ready", 64'(in_ready), 64'h1);

      for (int i = 0; i < 400; i++) begin
         a = rand_op();
         b = rand_op();
         cycle(1'b1, ($urandom_range(0, 3) != 0), a, b,
               ($urandom_range(0, 7) == 0) ? {$urandom, $urandom} : gen_raw(a, b),
               ($urandom_range(0, 3) != 0), ($urandom_range(0, 9) == 0), acc);
      end
      for (int i = 0; i < 3; i++)
         cycle(1'b1, 1'b0, '0, '0, '0, 1'b1, 1'b0, acc);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
